// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and a window helper.
// Used by vga_sync_gen, vga_pixel_tick and the pong pixel generators.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int DIV_W   = 4;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // True when coordinate c lies in the inclusive range [lo, hi].
    function automatic logic in_window(
        input logic [COORD_W-1:0] c,
        input int                 lo,
        input int                 hi
    );
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: mod-CLK_DIV divider producing a one-clk pixel strobe.
// Ports: i_clk, i_rst (async, active-high), o_p_tick (strobe).
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_p_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
        $error("CLK_DIV must be within 1..16");
    end

    logic [DIV_W-1:0] r_div_cnt;

    // With CLK_DIV = 1 the counter sits at 0 == DIV_LAST, so the tick is
    // permanently high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_p_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA x/y counters, video_on, registered hsync/vsync.
// Ports: clk, reset (async high), p_tick, x, y, video_on, hsync, vsync,
// frame_tick. Optional macro FRAME_TICK_EN builds the frame_tick pulse.
module vga_sync_gen #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK      = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] x,
    output logic [vga_timing_pkg::COORD_W-1:0] y,
    output logic                               video_on,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               frame_tick
);

    localparam int CW      = vga_timing_pkg::COORD_W;
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_DISPLAY + H_FRONT;
    localparam int HS_HI   = HS_LO + H_SYNC - 1;
    localparam int VS_LO   = V_DISPLAY + V_FRONT;
    localparam int VS_HI   = VS_LO + V_SYNC - 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    if (H_TOTAL > (1 << CW)) begin : g_h_chk
        $error("H_TOTAL exceeds 10-bit counter range");
    end
    if (V_TOTAL > (1 << CW)) begin : g_v_chk
        $error("V_TOTAL exceeds 10-bit counter range");
    end

    logic          w_p_tick;
    logic          w_h_end;
    logic          w_v_end;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          r_hsync;
    logic          r_vsync;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .i_clk    (clk),
        .i_rst    (reset),
        .o_p_tick (w_p_tick)
    );

    always_comb begin
        w_h_end  = (r_h_cnt == H_LAST);
        w_v_end  = (r_v_cnt == V_LAST);
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_p_tick) begin
            w_h_next = w_h_end ? '0 : r_h_cnt + 1'b1;
            if (w_h_end) begin
                w_v_next = w_v_end ? '0 : r_v_cnt + 1'b1;
            end
        end
    end

    // Sync is decoded from the next-state counts so the registered
    // pulses line up with x/y on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_hsync <= vga_timing_pkg::in_window(w_h_next, HS_LO, HS_HI)
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= vga_timing_pkg::in_window(w_v_next, VS_LO, VS_HI)
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign p_tick   = w_p_tick;
    assign x        = r_h_cnt;
    assign y        = r_v_cnt;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = (r_h_cnt < CW'(H_DISPLAY))
                   && (r_v_cnt < CW'(V_DISPLAY));

`ifdef FRAME_TICK_EN
    logic w_frame_end;
    logic r_frame_tick;

    // Registered on the wrap edge itself: high in the first (0,0) clk.
    assign w_frame_end = w_p_tick & w_h_end & w_v_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
        end
    end

    assign frame_tick = r_frame_tick;
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen, full-size line timing
// plus a shrunken-timing instance for frame-level behaviour.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_ft;
    logic [9:0] b_x, b_y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_ft;
    logic [9:0] s_x, s_y;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (b_p_tick),
        .x          (b_x),
        .y          (b_y),
        .video_on   (b_video_on),
        .hsync      (b_hsync),
        .vsync      (b_vsync),
        .frame_tick (b_ft)
    );

    // Small frame: H_TOTAL 15 (hsync 10..12), V_TOTAL 10 (vsync 7..8).
    vga_sync_gen #(
        .CLK_DIV     (2),
        .H_DISPLAY   (8),
        .H_FRONT     (2),
        .H_SYNC      (3),
        .H_BACK      (2),
        .V_DISPLAY   (6),
        .V_FRONT     (1),
        .V_SYNC      (2),
        .V_BACK      (1),
        .SYNC_ACTIVE (1'b0)
    ) dut_s (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (s_p_tick),
        .x          (s_x),
        .y          (s_y),
        .video_on   (s_video_on),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .frame_tick (s_ft)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input string tag, input int tx, input int ty,
                          input int budget);
        int k;
        k = 0;
        while (!(b_x == 10'(tx) && b_y == 10'(ty)) && k < budget) begin
            step(1);
            k++;
        end
        check(tag, int'(b_x == 10'(tx) && b_y == 10'(ty)), 1);
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, vo_fall;
        int wraps, w1, w2, ft_cnt, ft_bad, vs_bad, vs_ticks, vo_bad;
        int exp_ft, ft_post, k;
        logic [9:0] px, py;
        logic new00;

        // Reset state
        step(2);
        check("rst_x", b_x, 0);
        check("rst_y", b_y, 0);
        check("rst_ptick", b_p_tick, 0);
        check("rst_hsync", b_hsync, 1);
        check("rst_vsync", b_vsync, 1);
        check("rst_video", b_video_on, 1);
        check("rst_ft", b_ft, 0);
        check("rst_s_hsync", s_hsync, 1);

        // Tick cadence over 40 clks after release
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            check($sformatf("tick_p%0d", n), b_p_tick, int'(n % 4 == 0));
            check($sformatf("tick_x%0d", n), b_x, (n - 1) / 4);
            step(1);
        end

        // Line wrap
        wait_b("reach_799_0", 799, 0, 4000);
        step(3);
        check("pre_wrap_ptick", b_p_tick, 1);
        check("pre_wrap_x", b_x, 799);
        check("pre_wrap_y", b_y, 0);
        step(1);
        check("wrap_x", b_x, 0);
        check("wrap_y", b_y, 1);

        // Hsync window and video_on fall over line 1
        hs_cnt = 0;
        hs_first = -1;
        hs_last = -1;
        vo_fall = -1;
        for (int i = 0; i < 3200; i++) begin
            if (b_p_tick) begin
                if (b_hsync == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(b_x);
                    hs_last = int'(b_x);
                end
                if (!b_video_on && vo_fall < 0) vo_fall = int'(b_x);
            end
            step(1);
        end
        check("hs_ticks", hs_cnt, 96);
        check("hs_first", hs_first, 656);
        check("hs_last", hs_last, 751);
        check("video_fall_x", vo_fall, 640);
        check("line2_x", b_x, 0);
        check("line2_y", b_y, 2);

        // Reset mid-line while hsync is asserted
        wait_b("reach_700_2", 700, 2, 4000);
        check("hs_at_700", b_hsync, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_x", b_x, 0);
        check("mid_rst_y", b_y, 0);
        check("mid_rst_hsync", b_hsync, 1);
        check("mid_rst_vsync", b_vsync, 1);
        check("mid_rst_ptick", b_p_tick, 0);

        // Frame-level behaviour on the small instance
        step(1);
        reset = 1'b0;
        wraps = 0; w1 = -1; w2 = -1; ft_cnt = 0; ft_bad = 0;
        vs_bad = 0; vs_ticks = 0; vo_bad = 0;
        px = s_x;
        py = s_y;
        for (int n = 1; n <= 650; n++) begin
            new00 = (n > 1) && px == 10'd14 && py == 10'd9
                    && s_x == 10'd0 && s_y == 10'd0;
            if (new00) begin
                wraps++;
                if (w1 < 0) w1 = n;
                else if (w2 < 0) w2 = n;
                if (!s_video_on) vo_bad++;
            end
            if (s_vsync == 1'b0 && !(s_y == 10'd7 || s_y == 10'd8)) vs_bad++;
            if (s_p_tick && s_vsync == 1'b0) vs_ticks++;
            if (s_y >= 10'd6 && s_video_on) vo_bad++;
            if (s_ft) ft_cnt++;
`ifdef FRAME_TICK_EN
            exp_ft = int'(new00);
`else
            exp_ft = 0;
`endif
            if (int'(s_ft) != exp_ft) ft_bad++;
            px = s_x;
            py = s_y;
            step(1);
        end
        check("frame_wraps", wraps, 2);
        check("frame_first", w1, 301);
        check("frame_period", w2 - w1, 300);
        check("vs_ticks", vs_ticks, 60);
        check("vs_outside", vs_bad, 0);
        check("video_blank", vo_bad, 0);
`ifdef FRAME_TICK_EN
        check("ft_count", ft_cnt, 2);
`else
        check("ft_count", ft_cnt, 0);
`endif
        check("ft_align", ft_bad, 0);

        // Small instance: reset during vsync
        k = 0;
        while (s_y != 10'd7 && k < 400) begin
            step(1);
            k++;
        end
        check("s_reach_y7", s_y, 7);
        check("s_vs_y7", s_vsync, 0);
        reset = 1'b1;
        #1;
        check("s_rst_vsync", s_vsync, 1);
        check("s_rst_x", s_x, 0);
        check("s_rst_y", s_y, 0);
        check("s_rst_ft", s_ft, 0);
        ft_post = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (s_ft) ft_post++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_ft) ft_post++;
            step(1);
        end
        check("ft_post_rst", ft_post, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
